// File: rtl/ftwiddle_seq_pkg.sv
// +---------------------------------------------------------------------------+
// | ftwiddle_seq_pkg : shared defaults, stage width and FSM encoding for the  |
// |                    FFT twiddle/address sequencer.                         |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

package ftwiddle_seq_pkg;

    localparam int LOG2N_DEFAULT = 11;
    localparam int TW_W_DEFAULT  = LOG2N_DEFAULT - 1;
    localparam int STAGE_W       = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/ftw_bfly_addr.sv
// +---------------------------------------------------------------------------+
// | ftw_bfly_addr : combinational map from (stage, butterfly) to twiddle      |
// |                 index, A/B operand addresses and last flags.              |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

module ftw_bfly_addr
    import ftwiddle_seq_pkg::*;
#(
    parameter int LOG2N = LOG2N_DEFAULT,
    parameter int TW_W  = LOG2N - 1
) (
    input  logic [STAGE_W-1:0] stage,
    input  logic [LOG2N-2:0]   bfly,
    output logic [TW_W-1:0]    idx,
    output logic [LOG2N-1:0]   addr_a,
    output logic [LOG2N-1:0]   addr_b,
    output logic               stage_last,
    output logic               frame_last
);

    localparam logic [LOG2N-2:0]   BFLY_MAX  = '1;
    localparam logic [STAGE_W-1:0] STAGE_MAX = STAGE_W'(LOG2N - 1);

    logic [LOG2N-1:0]   bfly_ext;
    logic [LOG2N-1:0]   half;
    logic [LOG2N-1:0]   low;
    logic [LOG2N-1:0]   high_part;
    logic [STAGE_W-1:0] tw_shift;

    always_comb begin
        bfly_ext  = {1'b0, bfly};
        half      = LOG2N'(1) << stage;
        low       = bfly_ext & (half - LOG2N'(1));
        // Upper bits of j move up one place to open a zero hole at bit s.
        high_part = (bfly_ext >> stage) << (stage + STAGE_W'(1));
        addr_a    = high_part + low;
        addr_b    = addr_a + half;
        tw_shift  = STAGE_MAX - stage;
        idx       = TW_W'(low << tw_shift);
    end

    assign stage_last = (bfly == BFLY_MAX);
    assign frame_last = stage_last && (stage == STAGE_MAX);

endmodule

`default_nettype wire

// File: rtl/ftwiddle_seq.sv
// +---------------------------------------------------------------------------+
// | ftwiddle_seq : radix-2 DIT FFT sequencer emitting one registered         |
// |                {idx, a, b, stage, last} tuple per butterfly (valid/ready).|
// |                Optional IFFT conjugate control under `FTW_IFFT_EN.        |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

module ftwiddle_seq
    import ftwiddle_seq_pkg::*;
#(
    parameter int LOG2N = LOG2N_DEFAULT,
    parameter int TW_W  = LOG2N - 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic               i_abort,
    output logic               o_busy,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [TW_W-1:0]    o_idx,
    output logic [LOG2N-1:0]   o_addr_a,
    output logic [LOG2N-1:0]   o_addr_b,
    output logic [STAGE_W-1:0] o_stage,
    output logic               o_stage_last,
    output logic               o_frame_last,
`ifdef FTW_IFFT_EN
    input  logic               i_ifft,
    output logic               o_conj,
`endif
    output logic               o_done
);

    localparam int BW = LOG2N - 1;

    state_t             state, state_nxt;
    logic               load_first, advance, clear;
    logic               valid_q, stage_last_q, frame_last_q;
    logic [STAGE_W-1:0] stage_q, stage_nxt;
    logic [BW-1:0]      bfly_q, bfly_nxt;
    logic [TW_W-1:0]    idx_q, map_idx;
    logic [LOG2N-1:0]   addr_a_q, addr_b_q, map_a, map_b;
    logic               map_stage_last, map_frame_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Abort outranks both start and the handshake.
    always_comb begin
        state_nxt  = state;
        load_first = 1'b0;
        advance    = 1'b0;
        clear      = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_start && !i_abort) begin
                    state_nxt  = S_RUN;
                    load_first = 1'b1;
                end
            end
            S_RUN: begin
                if (i_abort) begin
                    state_nxt = S_IDLE;
                    clear     = 1'b1;
                end else if (valid_q && i_ready) begin
                    if (frame_last_q) begin
                        state_nxt = S_DONE;
                        clear     = 1'b1;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            S_DONE: state_nxt = S_IDLE;
            default: begin
                state_nxt = S_IDLE;
                clear     = 1'b1;
            end
        endcase
    end

    // Next (s, j); zero when loading the first tuple of a frame.
    always_comb begin
        stage_nxt = '0;
        bfly_nxt  = '0;
        if (advance) begin
            if (stage_last_q) begin
                stage_nxt = stage_q + STAGE_W'(1);
                bfly_nxt  = '0;
            end else begin
                stage_nxt = stage_q;
                bfly_nxt  = bfly_q + BW'(1);
            end
        end
    end

    ftw_bfly_addr #(
        .LOG2N (LOG2N),
        .TW_W  (TW_W)
    ) u_map (
        .stage      (stage_nxt),
        .bfly       (bfly_nxt),
        .idx        (map_idx),
        .addr_a     (map_a),
        .addr_b     (map_b),
        .stage_last (map_stage_last),
        .frame_last (map_frame_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q      <= 1'b0;
            stage_q      <= '0;
            bfly_q       <= '0;
            idx_q        <= '0;
            addr_a_q     <= '0;
            addr_b_q     <= '0;
            stage_last_q <= 1'b0;
            frame_last_q <= 1'b0;
        end else if (load_first || advance) begin
            valid_q      <= 1'b1;
            stage_q      <= stage_nxt;
            bfly_q       <= bfly_nxt;
            idx_q        <= map_idx;
            addr_a_q     <= map_a;
            addr_b_q     <= map_b;
            stage_last_q <= map_stage_last;
            frame_last_q <= map_frame_last;
        end else if (clear) begin
            valid_q      <= 1'b0;
            stage_q      <= '0;
            bfly_q       <= '0;
            idx_q        <= '0;
            addr_a_q     <= '0;
            addr_b_q     <= '0;
            stage_last_q <= 1'b0;
            frame_last_q <= 1'b0;
        end
    end

`ifdef FTW_IFFT_EN
    logic conj_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     conj_q <= 1'b0;
        else if (load_first)         conj_q <= i_ifft;
        else if (state_nxt == S_IDLE) conj_q <= 1'b0;
    end

    assign o_conj = conj_q;
`else
    // Forward transform only: no conjugate control is generated.
`endif

    assign o_busy       = (state == S_RUN) || (state == S_DONE);
    assign o_done       = (state == S_DONE);
    assign o_valid      = valid_q;
    assign o_idx        = idx_q;
    assign o_addr_a     = addr_a_q;
    assign o_addr_b     = addr_b_q;
    assign o_stage      = stage_q;
    assign o_stage_last = stage_last_q;
    assign o_frame_last = frame_last_q;

endmodule

`default_nettype wire

// File: tb/tb_ftwiddle_seq.sv
// +---------------------------------------------------------------------------+
// | tb_ftwiddle_seq : directed self-checking bench for ftwiddle_seq at        |
// |                   LOG2N=3 and LOG2N=11 (default build).                   |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_ftwiddle_seq;

    logic        clk = 1'b0;
    logic        rst;

    logic        start3, abort3, ready3;
    logic        busy3, valid3, sl3, fl3, done3;
    logic [1:0]  idx3;
    logic [2:0]  a3, b3;
    logic [3:0]  stage3;

    logic        start11, abort11, ready11;
    logic        busy11, valid11, sl11, fl11, done11;
    logic [9:0]  idx11;
    logic [10:0] a11, b11;
    logic [3:0]  stage11;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ftwiddle_seq #(.LOG2N(3), .TW_W(2)) dut3 (
        .clk(clk), .rst(rst), .i_start(start3), .i_abort(abort3),
        .o_busy(busy3), .o_valid(valid3), .i_ready(ready3),
        .o_idx(idx3), .o_addr_a(a3), .o_addr_b(b3), .o_stage(stage3),
        .o_stage_last(sl3), .o_frame_last(fl3), .o_done(done3)
    );

    ftwiddle_seq #(.LOG2N(11), .TW_W(10)) dut11 (
        .clk(clk), .rst(rst), .i_start(start11), .i_abort(abort11),
        .o_busy(busy11), .o_valid(valid11), .i_ready(ready11),
        .o_idx(idx11), .o_addr_a(a11), .o_addr_b(b11), .o_stage(stage11),
        .o_stage_last(sl11), .o_frame_last(fl11), .o_done(done11)
    );

    // Hand-computed N=8 table: {idx, a, b, stage_last, frame_last}
    function automatic logic [9:0] exp3(input int t);
        logic [1:0] i;
        logic [2:0] a, b;
        case (t)
            0:  {i, a, b} = {2'd0, 3'd0, 3'd1};
            1:  {i, a, b} = {2'd0, 3'd2, 3'd3};
            2:  {i, a, b} = {2'd0, 3'd4, 3'd5};
            3:  {i, a, b} = {2'd0, 3'd6, 3'd7};
            4:  {i, a, b} = {2'd0, 3'd0, 3'd2};
            5:  {i, a, b} = {2'd2, 3'd1, 3'd3};
            6:  {i, a, b} = {2'd0, 3'd4, 3'd6};
            7:  {i, a, b} = {2'd2, 3'd5, 3'd7};
            8:  {i, a, b} = {2'd0, 3'd0, 3'd4};
            9:  {i, a, b} = {2'd1, 3'd1, 3'd5};
            10: {i, a, b} = {2'd2, 3'd2, 3'd6};
            default: {i, a, b} = {2'd3, 3'd3, 3'd7};
        endcase
        return {i, a, b, (t % 4 == 3), (t == 11)};
    endfunction

    // N=2048 reference: a is j with a zero inserted at bit s.
    function automatic logic [33:0] exp11(input int n);
        int s, j, low, high, a, b, idx;
        s    = n / 1024;
        j    = n % 1024;
        low  = j % (2 ** s);
        high = j / (2 ** s);
        a    = high * (2 ** (s + 1)) + low;
        b    = a + 2 ** s;
        idx  = low * (2 ** (10 - s));
        return {10'(idx), 11'(a), 11'(b), (j == 1023), (n == 11263)};
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        start3 = 0; abort3 = 0; ready3 = 0;
        start11 = 0; abort11 = 0; ready11 = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({valid3, busy3, done3, idx3, a3, b3, stage3, sl3, fl3} !== 17'd0) begin
            errors++;
            $display("FAIL reset3: got %b required 0", {valid3, busy3, done3, idx3, a3, b3, stage3, sl3, fl3});
        end
        checks++;
        if ({valid11, busy11, done11, idx11, a11, b11, stage11, sl11, fl11} !== 41'd0) begin
            errors++;
            $display("FAIL reset11: got %h required 0", {valid11, busy11, done11, idx11, a11, b11, stage11, sl11, fl11});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({valid3, busy3, done3} !== 3'b000) begin
            errors++;
            $display("FAIL idle_after_reset: got %b required 000", {valid3, busy3, done3});
        end
    endtask

    task automatic test_frame3;
        start3 = 1; ready3 = 1;
        @(negedge clk);
        start3 = 0;
        for (int t = 0; t < 12; t++) begin
            checks++;
            if ({valid3, busy3, done3, stage3, idx3, a3, b3, sl3, fl3} !== {3'b110, 4'(t / 4), exp3(t)}) begin
                errors++;
                $display("FAIL frame3_t%0d: got v%b s%0d idx%0d a%0d b%0d sl%b fl%b required s%0d tuple %b",
                         t, valid3, stage3, idx3, a3, b3, sl3, fl3, t / 4, exp3(t));
            end
            @(negedge clk);
        end
        checks++;
        if ({valid3, done3, busy3} !== 3'b011) begin
            errors++;
            $display("FAIL frame3_done: got v/d/b %b required 011", {valid3, done3, busy3});
        end
        start3 = 1;
        @(negedge clk);
        start3 = 0;
        checks++;
        if ({valid3, done3, busy3} !== 3'b000) begin
            errors++;
            $display("FAIL start_in_done: got v/d/b %b required 000", {valid3, done3, busy3});
        end
        @(negedge clk);
        checks++;
        if ({valid3, busy3} !== 2'b00) begin
            errors++;
            $display("FAIL start_in_done_later: got v/b %b required 00", {valid3, busy3});
        end
    endtask

    task automatic test_stall3;
        logic [31:0] pat = 32'b1011_0010_0111_0001_1100_1011_0110_1001;
        logic [9:0]  held = '0;
        logic [3:0]  held_stage = '0;
        logic        stalled = 0;
        int          n = 0;
        bit          ok = 0;
        start3 = 1; ready3 = 0;
        @(negedge clk);
        start3 = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            start3 = (cyc == 3);
            checks++;
            if (valid3 !== 1'b1) begin
                errors++;
                $display("FAIL stall_valid: got %b required 1 at tuple %0d", valid3, n);
                break;
            end
            checks++;
            if ({idx3, a3, b3, sl3, fl3, stage3} !== {exp3(n), 4'(n / 4)}) begin
                errors++;
                $display("FAIL stall_seq_%0d: got %b s%0d required %b s%0d",
                         n, {idx3, a3, b3, sl3, fl3}, stage3, exp3(n), n / 4);
            end
            if (stalled) begin
                checks++;
                if ({idx3, a3, b3, sl3, fl3, stage3} !== {held, held_stage}) begin
                    errors++;
                    $display("FAIL stall_hold: got %b required %b", {idx3, a3, b3, sl3, fl3, stage3}, {held, held_stage});
                end
            end
            ready3     = pat[cyc % 32];
            held       = {idx3, a3, b3, sl3, fl3};
            held_stage = stage3;
            stalled    = !ready3;
            if (ready3) begin
                n++;
                if (n == 12) begin
                    ok = 1;
                    break;
                end
            end
            @(negedge clk);
        end
        start3 = 0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL stall_complete: got %0d handshakes required 12", n);
        end
        @(negedge clk);
        ready3 = 0;
        checks++;
        if ({valid3, done3, busy3} !== 3'b011) begin
            errors++;
            $display("FAIL stall_done: got v/d/b %b required 011", {valid3, done3, busy3});
        end
        @(negedge clk);
        checks++;
        if ({valid3, done3, busy3} !== 3'b000) begin
            errors++;
            $display("FAIL stall_idle: got v/d/b %b required 000", {valid3, done3, busy3});
        end
    endtask

    task automatic test_rst_mid;
        start3 = 1; ready3 = 1;
        @(negedge clk);
        start3 = 0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({valid3, busy3, done3, idx3, a3, b3, stage3, sl3, fl3} !== 17'd0) begin
            errors++;
            $display("FAIL rst_mid: got %b required 0", {valid3, busy3, done3, idx3, a3, b3, stage3, sl3, fl3});
        end
        @(negedge clk);
        rst = 1'b0; ready3 = 0;
        @(negedge clk);
        checks++;
        if ({valid3, busy3, done3} !== 3'b000) begin
            errors++;
            $display("FAIL rst_mid_idle: got %b required 000", {valid3, busy3, done3});
        end
    endtask

    task automatic test_abort11;
        start11 = 1; ready11 = 1;
        @(negedge clk);
        start11 = 0;
        repeat (4196) @(negedge clk);
        checks++;
        if ({valid11, stage11, idx11, a11, b11} !== {1'b1, 4'd4, 10'd256, 11'd196, 11'd212}) begin
            errors++;
            $display("FAIL abort_point: got v%b s%0d idx%0d a%0d b%0d required v1 s4 idx256 a196 b212",
                     valid11, stage11, idx11, a11, b11);
        end
        abort11 = 1;
        @(negedge clk);
        abort11 = 0;
        checks++;
        if ({valid11, busy11, done11} !== 3'b000) begin
            errors++;
            $display("FAIL abort_stop: got v/b/d %b required 000", {valid11, busy11, done11});
        end
        @(negedge clk);
        checks++;
        if ({valid11, busy11, done11} !== 3'b000) begin
            errors++;
            $display("FAIL abort_no_done: got v/b/d %b required 000", {valid11, busy11, done11});
        end
        start11 = 1;
        @(negedge clk);
        start11 = 0;
        checks++;
        if ({valid11, busy11, stage11, idx11, a11, b11, sl11, fl11} !==
            {1'b1, 1'b1, 4'd0, 10'd0, 11'd0, 11'd1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL abort_restart: got v%b b%b s%0d idx%0d a%0d b%0d required v1 b1 s0 idx0 a0 b1",
                     valid11, busy11, stage11, idx11, a11, b11);
        end
    endtask

    // Continues the frame restarted by test_abort11; tuple 0 is on the outputs.
    task automatic test_full11;
        int n = 0;
        int dones = 0;
        for (int cyc = 0; cyc < 12000 && n < 11264; cyc++) begin
            checks++;
            if (valid11 !== 1'b1 || done11 !== 1'b0) begin
                errors++;
                $display("FAIL full_valid: got v%b d%b required v1 d0 at tuple %0d", valid11, done11, n);
                break;
            end
            checks++;
            if ({idx11, a11, b11, sl11, fl11, stage11} !== {exp11(n), 4'(n / 1024)}) begin
                errors++;
                $display("FAIL full_seq_%0d: got s%0d idx%0d a%0d b%0d sl%b fl%b required %h",
                         n, stage11, idx11, a11, b11, sl11, fl11, exp11(n));
                break;
            end
            if (n == 11263) begin
                checks++;
                if ({stage11, idx11, a11, b11, fl11} !== {4'd10, 10'd1023, 11'd1023, 11'd2047, 1'b1}) begin
                    errors++;
                    $display("FAIL full_last: got s%0d idx%0d a%0d b%0d fl%b required s10 idx1023 a1023 b2047 fl1",
                             stage11, idx11, a11, b11, fl11);
                end
            end
            n++;
            @(negedge clk);
        end
        checks++;
        if (n !== 11264) begin
            errors++;
            $display("FAIL full_count: got %0d handshakes required 11264", n);
        end
        for (int k = 0; k < 4; k++) begin
            if (done11) dones++;
            if (k == 0) begin
                checks++;
                if ({valid11, done11} !== 2'b01) begin
                    errors++;
                    $display("FAIL full_done: got v/d %b required 01", {valid11, done11});
                end
            end
            @(negedge clk);
        end
        checks++;
        if (dones !== 1 || busy11 !== 1'b0) begin
            errors++;
            $display("FAIL full_done_once: got %0d pulses busy %b required 1 pulse busy 0", dones, busy11);
        end
    endtask

    initial begin
        test_reset();
        test_frame3();
        test_stall3();
        test_rst_mid();
        test_abort11();
        test_full11();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
